// File: rtl/soqpsk_rom_sequencer.sv
// Symbol-rate controller for the 512x14 SOQPSK waveform ROM.
// Accepts precoder bits, keeps a 3-bit symbol history plus symbol parity,
// and time-shares the single ROM port between I and Q reads for each of the
// 16 samples of a symbol, delivering registered I/Q pairs downstream.
//
// Handshakes (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high. Input side: sym_valid may wait on
// sym_ready and is not required to be held. Output side: once out_valid is
// high, i_out/q_out/out_valid stay unchanged until the edge where out_ready
// is also high.
module soqpsk_rom_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        sym_valid,
  input  logic        sym_bit,
  output logic        sym_ready,
  output logic [8:0]  rom_address,
  input  logic [13:0] rom_q,
  output logic [13:0] i_out,
  output logic [13:0] q_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        underrun,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_I = 3'd1,
    RD_Q = 3'd2,
    CAP  = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  hist;
  logic        par;
  logic        cur_par;
  logic [3:0]  sample;
  logic [13:0] i_hold;

  logic        last_sample;
  logic        pair_taken;
  logic        accept;

  assign last_sample = (sample == 4'd15);
  assign pair_taken  = (state == WAIT) && out_ready;
  // New symbols are taken only from IDLE or on the final pair's handshake,
  // which gives back-to-back symbols with no gap.
  assign sym_ready   = enable && ((state == IDLE) || (pair_taken && last_sample));
  assign accept      = sym_valid && sym_ready;
  // Symbol ends while enabled but the source has nothing ready.
  assign underrun    = pair_taken && last_sample && enable && !sym_valid;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: fixed RD_I -> RD_Q -> CAP -> WAIT walk per sample.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RD_I;
      RD_I: state_nxt = RD_Q;
      RD_Q: state_nxt = CAP;
      CAP:  state_nxt = WAIT;
      WAIT: begin
        if (out_ready) begin
          if (!last_sample || accept) state_nxt = RD_I;
          else                        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: symbol history, parity, sample counter, ROM address, output pair.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist        <= 3'd0;
      par         <= 1'b0;
      cur_par     <= 1'b0;
      sample      <= 4'd0;
      rom_address <= 9'd0;
      i_hold      <= 14'd0;
      i_out       <= 14'd0;
      q_out       <= 14'd0;
      out_valid   <= 1'b0;
    end else if (accept) begin
      // hist[2] is the newest bit; the address uses the parity before toggling.
      hist        <= {sym_bit, hist[2:1]};
      cur_par     <= par;
      par         <= ~par;
      sample      <= 4'd0;
      rom_address <= {sym_bit, hist[2:1], par, 1'b0, 4'd0};
      out_valid   <= 1'b0;
    end else begin
      case (state)
        RD_I: rom_address[4] <= 1'b1;          // switch to the Q channel
        RD_Q: i_hold <= rom_q;                 // I word from the previous read
        CAP: begin
          i_out     <= i_hold;
          q_out     <= rom_q;                  // Q word arrives now
          out_valid <= 1'b1;
        end
        WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!last_sample) begin
              sample      <= sample + 4'd1;
              rom_address <= {hist, cur_par, 1'b0, sample + 4'd1};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_soqpsk_rom_sequencer.sv
// Self-checking bench for soqpsk_rom_sequencer. The ROM model returns its
// address as data, so every I/Q pair names the address that produced it.
module tb_soqpsk_rom_sequencer;

  // ---------------- clock / reset / signals ----------------
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sym_valid = 1'b0;
  logic        sym_bit = 1'b0;
  logic        out_ready = 1'b1;
  logic        sym_ready;
  logic [8:0]  rom_address;
  logic [13:0] rom_q = 14'd0;
  logic [13:0] i_out;
  logic [13:0] q_out;
  logic        out_valid;
  logic        busy;
  logic        underrun;
  logic [2:0]  state_dbg;

  always #5 clock = ~clock;

  // Registered ROM: data = address, one cycle latency.
  always @(posedge clock) rom_q <= {5'd0, rom_address};

  soqpsk_rom_sequencer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .sym_valid   (sym_valid),
    .sym_bit     (sym_bit),
    .sym_ready   (sym_ready),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .i_out       (i_out),
    .q_out       (q_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .underrun    (underrun),
    .state_dbg   (state_dbg)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [27:0] exp_q[$];
  logic [27:0] exp_pair;
  logic [2:0]  m_hist = 3'd0;
  logic        m_par = 1'b0;
  logic [8:0]  m_addr = 9'd0;
  logic [8:0]  ia;
  logic        prev_valid = 1'b0;
  int cyc = 0, ref_cyc = 0, sym_acc_cyc = 0, sym_hs = 0, sym_len = 0;
  int hs_cnt = 0, und_cnt = 0, acc_cnt = 0, addr_pend = 0;

  // Inputs change 1 ns after the rising edge, so the falling edge sees the
  // values the next rising edge will act on.
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      m_hist = 3'd0;
      m_par = 1'b0;
      exp_q.delete();
      addr_pend = 0;
      prev_valid = 1'b0;
      sym_hs = 0;
    end else begin
      if (addr_pend == 2)      check("addr_i", 32'(rom_address), 32'(m_addr));
      else if (addr_pend == 1) check("addr_q", 32'(rom_address), 32'(m_addr | 9'h010));
      if (addr_pend > 0) addr_pend--;

      // A pair becomes valid 4 falling edges after the accept or the previous handshake.
      if (out_valid && !prev_valid) check("valid_lat", 32'(cyc - ref_cyc), 32'd4);

      if (out_valid && out_ready) begin
        hs_cnt++;
        sym_hs++;
        ref_cyc = cyc;
        if (exp_q.size() == 0) check("pair_unexpected", 32'd1, 32'd0);
        else begin
          exp_pair = exp_q.pop_front();
          check("pair", 32'({i_out, q_out}), 32'(exp_pair));
        end
        if (sym_hs == 16) sym_len = cyc - sym_acc_cyc;
      end

      if (underrun) begin
        und_cnt++;
        check("underrun_at_end", 32'(out_valid && out_ready && (sym_hs == 16) && !sym_valid), 32'd1);
      end

      if (sym_valid && sym_ready) begin
        m_hist = {sym_bit, m_hist[2:1]};
        m_addr = {m_hist, m_par, 5'd0};
        for (int s = 0; s < 16; s++) begin
          ia = {m_hist, m_par, 1'b0, 4'(s)};
          exp_q.push_back({5'd0, ia, 5'd0, ia | 9'h010});
        end
        m_par = ~m_par;
        addr_pend = 2;
        sym_acc_cyc = cyc;
        ref_cyc = cyc;
        sym_hs = 0;
        acc_cnt++;
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Present one bit and return in the cycle after it is accepted (RD_I).
  task automatic send_bit(input logic b);
    logic took;
    sym_bit = b;
    sym_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      took = sym_valid && sym_ready;
      @(posedge clock);
      #1;
      if (took) return;
    end
    check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clock);
      #1;
      if (!busy) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_hs(input int k);
    for (int n = 0; n < 2000; n++) begin
      @(posedge clock);
      #1;
      if (sym_hs == k) return;
    end
    check("hs_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 100; n++) begin
      if (out_valid) return;
      @(posedge clock);
      #1;
    end
    check("valid_timeout", 32'd1, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [13:0] held_i, held_q;
  int acc_snap;

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_addr", 32'(rom_address), 32'd0);
    check("rst_iq", 32'({i_out, q_out}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_ready_en0", 32'(sym_ready), 32'd0);
    enable = 1'b1;
    #1;
    check("rst_ready_en1", 32'(sym_ready), 32'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Three back-to-back symbols 1,0,1 with out_ready high.
    send_bit(1'b1);
    check("sym0_addr", 32'(rom_address), 32'h100);
    check("sym0_busy", 32'(busy), 32'd1);
    send_bit(1'b0);
    check("sym1_addr", 32'(rom_address), 32'h0A0);
    send_bit(1'b1);
    check("sym2_addr", 32'(rom_address), 32'h140);
    sym_valid = 1'b0;
    wait_idle();
    check("t1_pairs", 32'(hs_cnt), 32'd48);
    check("t1_sym_len", 32'(sym_len), 32'd64);
    check("t1_underrun_cnt", 32'(und_cnt), 32'd1);
    check("t1_ready_idle", 32'(sym_ready), 32'd1);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Enable drops at sample 3: symbol completes, no underrun, no new accept.
    send_bit(1'b0);
    wait_hs(3);
    enable = 1'b0;
    wait_idle();
    check("t2_pairs", 32'(sym_hs), 32'd16);
    check("t2_underrun_cnt", 32'(und_cnt), 32'd1);
    acc_snap = acc_cnt;
    repeat (8) @(posedge clock);
    #1;
    check("t2_ready_low", 32'(sym_ready), 32'd0);
    check("t2_no_accept", 32'(acc_cnt), 32'(acc_snap));

    // Stall 7 cycles at sample 5.
    enable = 1'b1;
    send_bit(1'b1);
    sym_valid = 1'b0;
    wait_hs(5);
    out_ready = 1'b0;
    wait_valid();
    held_i = i_out;
    held_q = q_out;
    repeat (6) begin
      @(posedge clock);
      #1;
      check("stall_hold", 32'({out_valid, i_out, q_out}), 32'({1'b1, held_i, held_q}));
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_idle();
    check("t3_sym_len", 32'(sym_len), 32'd71);
    check("t3_underrun_cnt", 32'(und_cnt), 32'd2);
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset at sample 9 of the third symbol.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    sym_valid = 1'b0;
    wait_hs(9);
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_addr", 32'(rom_address), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    send_bit(1'b1);
    check("post_rst_addr", 32'(rom_address), 32'h100);
    sym_valid = 1'b0;
    wait_idle();
    check("t4_pairs", 32'(sym_hs), 32'd16);
    check("t4_underrun_cnt", 32'(und_cnt), 32'd3);
    check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
